sdm1b_decim: RTL and testbench

Sigma-delta demodulator: recovers W-bit unsigned PCM from the 1-bit bitstream produced by the team's first-order 1-bit modulator. Implemented as an N-stage CIC decimator with decimation ratio R = 2^LOG2R. It sits on the receive/loopback side of the bitstream link, or after an external 1-bit modulator, in the clk_fast domain. It emits one PCM word per R accepted bits, flagged by a single-cycle strobe.

---
 rtl/sdm1b_decim.sv | 90 +++++++++
 tb/tb_sdm1b_decim.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sdm1b_decim.sv
// N-stage CIC decimator (ratio 2^LOG2R) recovering W-bit unsigned PCM from a 1-bit sigma-delta stream.
// Optional feature macro SDM_DECIM_SAT_EN: clamp full scale to 2^W-1 and drive the sticky sat flag.
module sdm1b_decim #(
  parameter int unsigned W     = 12,
  parameter int unsigned N     = 2,
  parameter int unsigned LOG2R = 6
) (
  input  logic         clk_fast,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         din,
  output logic [W-1:0] pcm,
  output logic         pcm_valid,
  input  logic         sat_clr,
  output logic         sat
);
  localparam int unsigned G  = N * LOG2R + 1;
  localparam int unsigned SH = N * LOG2R - W;
  localparam int unsigned YW = G - SH;
  localparam logic [LOG2R-1:0] PH_LAST = '1;

  logic [G-1:0]     integ_q   [N];
  logic [G-1:0]     dly_q     [N];
  logic [G-1:0]     comb_in_c [N];
  logic [LOG2R-1:0] ph_q;
  logic             dec_c;
  logic [YW-1:0]    y_c;
  logic [W-1:0]     pcm_d;

  assign dec_c = ce && (ph_q == PH_LAST);

  // Comb chain from the pre-edge last integrator; comb_in_c[k] feeds delay k
  always_comb begin
    logic [G-1:0] c;
    c = integ_q[N-1];
    for (int k = 0; k < N; k++) begin
      comb_in_c[k] = c;
      c = c - dly_q[k];
    end
    y_c = YW'(c >> SH);
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= '0;
        dly_q[k]   <= '0;
      end
      ph_q      <= '0;
      pcm       <= '0;
      pcm_valid <= 1'b0;
    end else begin
      pcm_valid <= dec_c;
      if (ce) begin
        integ_q[0] <= integ_q[0] + G'(din);
        for (int k = 1; k < N; k++) begin
          integ_q[k] <= integ_q[k] + integ_q[k-1];
        end
        ph_q <= ph_q + LOG2R'(1);
      end
      if (dec_c) begin
        for (int k = 0; k < N; k++) begin
          dly_q[k] <= comb_in_c[k];
        end
        pcm <= pcm_d;
      end
    end
  end

`ifdef SDM_DECIM_SAT_EN
  // y exceeds 2^W-1 exactly when its top bit is set
  assign pcm_d = y_c[W] ? '1 : y_c[W-1:0];

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      sat <= 1'b0;
    end else if (dec_c && y_c[W]) begin
      sat <= 1'b1;
    end else if (sat_clr) begin
      sat <= 1'b0;
    end
  end
`else
  logic unused_sat;
  assign unused_sat = ^{sat_clr, y_c[W]};
  assign pcm_d      = y_c[W-1:0];
  assign sat        = 1'b0;
`endif

endmodule

// File: tb/tb_sdm1b_decim.sv
// Directed bench for sdm1b_decim at W=12, N=2, LOG2R=6; follows SDM_DECIM_SAT_EN like the design.
module tb_sdm1b_decim;
  localparam int R = 64;

  logic        clk_fast = 1'b0;
  logic        rst_n    = 1'b0;
  logic        ce       = 1'b0;
  logic        din      = 1'b0;
  logic        sat_clr  = 1'b0;
  logic [11:0] pcm;
  logic        pcm_valid;
  logic        sat;

`ifdef SDM_DECIM_SAT_EN
  localparam int SAT_ON = 1;
`else
  localparam int SAT_ON = 0;
`endif

  sdm1b_decim #(.W(12), .N(2), .LOG2R(6)) dut (
    .clk_fast (clk_fast),
    .rst_n    (rst_n),
    .ce       (ce),
    .din      (din),
    .pcm      (pcm),
    .pcm_valid(pcm_valid),
    .sat_clr  (sat_clr),
    .sat      (sat)
  );

  always #5 clk_fast = ~clk_fast;

  int total = 0;
  int bad   = 0;
  int cyc_cnt, nacc, macc, hold_err, last_pcm;
  int sp[$];
  int sc[$];
  bit bits[$];

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    cyc_cnt  = 0;
    nacc     = 0;
    macc     = 0;
    hold_err = 0;
    last_pcm = 0;
    sp.delete();
    sc.delete();
    bits.delete();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    ce      = 1'b0;
    din     = 1'b0;
    sat_clr = 1'b0;
    @(posedge clk_fast);
    #1;
    rst_n = 1'b1;
    clear_model();
  endtask

  // mode 0: zeros, 1: alternating 1,0, 2: ones, 3: alternating with ce every 3rd cycle, 4: modulator x=1000
  task automatic run(input int mode, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      logic b;
      logic e;
      int   sum;
      e   = (mode == 3) ? (cyc_cnt % 3 == 0) : 1'b1;
      sum = macc + 1000;
      case (mode)
        0:       b = 1'b0;
        2:       b = 1'b1;
        4:       b = (sum >= 4096);
        default: b = (nacc % 2 == 0);
      endcase
      ce  = e;
      din = b;
      @(posedge clk_fast);
      #1;
      cyc_cnt++;
      if (e) begin
        nacc++;
        bits.push_back(b);
        if (mode == 4) macc = b ? sum - 4096 : sum;
      end
      if (pcm_valid) begin
        sp.push_back(int'(pcm));
        sc.push_back(cyc_cnt);
      end else if (int'(pcm) != last_pcm) begin
        hold_err++;
      end
      last_pcm = int'(pcm);
    end
  endtask

  // Direct triangular-window convolution of accepted bits for strobe k (1-based)
  function automatic int fir(input int k);
    int m, acc, u;
    m   = k * R - 1;
    acc = 0;
    for (int s = m - 2 * R + 1; s <= m - 1; s++) begin
      if (s >= 1 && bits[s-1]) begin
        u = m - s;
        acc += (u <= R) ? u : 2 * R - u;
      end
    end
    return acc;
  endfunction

  initial begin
    int sum8, mean;

    repeat (2) @(posedge clk_fast);
    #1;
    check("rst_pcm", int'(pcm), 0);
    check("rst_valid", int'(pcm_valid), 0);
    check("rst_sat", int'(sat), 0);
    rst_n = 1'b1;
    clear_model();

    // constant zero
    run(0, 5 * R);
    check("zero_cnt", sp.size(), 5);
    for (int i = 0; i < sp.size(); i++) begin
      check("zero_pcm", sp[i], 0);
      check("zero_cyc", sc[i], R * (i + 1));
    end

    // alternating 1,0
    do_reset();
    run(1, 8 * R);
    check("alt_cnt", sp.size(), 8);
    check("alt_first", sp[0], 992);
    for (int i = 3; i < sp.size(); i++) check("alt_pcm", sp[i], 2048);

    // constant one: full scale, saturation and sat_clr behaviour
    do_reset();
    run(2, 5 * R);
    check("ones_cnt", sp.size(), 5);
    check("ones_s1", sp[0], 1953);
    check("ones_s2", sp[1], 4095);
    for (int i = 2; i < sp.size(); i++) check("ones_pcm", sp[i], SAT_ON ? 4095 : 0);
    check("ones_sat", int'(sat), SAT_ON);
    sat_clr = 1'b1;
    run(2, 1);
    sat_clr = 1'b0;
    check("sat_clr", int'(sat), 0);
    run(2, R - 2);
    check("sat_hold_clr", int'(sat), 0);
    run(2, 1);
    check("sat_reset_strobe", int'(pcm_valid), 1);
    check("sat_reset", int'(sat), SAT_ON);
    sat_clr = 1'b1;
    run(2, 1);
    sat_clr = 1'b0;
    check("sat_clr2", int'(sat), 0);
    run(2, R - 2);
    sat_clr = 1'b1;
    run(2, 1);
    sat_clr = 1'b0;
    check("sat_set_wins_strobe", int'(pcm_valid), 1);
    check("sat_set_wins", int'(sat), SAT_ON);

    // ce on every 3rd cycle
    do_reset();
    run(3, 8 * 3 * R);
    check("ce3_cnt", sp.size(), 8);
    check("ce3_first_cyc", sc[0], 3 * R - 2);
    for (int i = 1; i < sp.size(); i++) check("ce3_period", sc[i] - sc[i-1], 3 * R);
    for (int i = 3; i < sp.size(); i++) check("ce3_pcm", sp[i], 2048);
    check("ce3_hold", hold_err, 0);

    // mid-operation reset
    do_reset();
    run(1, 100);
    check("pre_rst_pcm", int'(pcm), 992);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pcm", int'(pcm), 0);
    check("mid_rst_valid", int'(pcm_valid), 0);
    @(posedge clk_fast);
    #1;
    rst_n = 1'b1;
    clear_model();
    run(1, R);
    check("post_rst_cnt", sp.size(), 1);
    check("post_rst_cyc", sc[0], R);
    check("post_rst_pcm", sp[0], 992);

    // first-order 12-bit modulator with input 1000
    do_reset();
    run(4, 12 * R);
    check("mod_cnt", sp.size(), 12);
    sum8 = 0;
    for (int i = 3; i < sp.size(); i++) check("mod_pcm", sp[i], fir(i + 1));
    for (int i = 4; i < sp.size(); i++) sum8 += sp[i];
    mean = sum8 / 8;
    check("mod_mean_dev", (mean < 999 || mean > 1001) ? mean - 1000 : 0, 0);
    check("mod_sat", int'(sat), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
